// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-RAM arbiter
package dmem_pkg;

    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;
    localparam logic [1:0] SZ_3B = 2'b11;

    localparam logic [3:0] RT_B  = 4'b0001;
    localparam logic [3:0] RT_H  = 4'b0010;
    localparam logic [3:0] RT_3B = 4'b0100;
    localparam logic [3:0] RT_W  = 4'b1000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin arbiter with last-grant register
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // On a tie, the port that did not win last time is granted
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req[PORT_LSU] && (!req[PORT_LDR] || last_q == PORT_LDR)) begin
                gnt[PORT_LSU] = 1'b1;
                last_d        = PORT_LSU;
            end else if (req[PORT_LDR]) begin
                gnt[PORT_LDR] = 1'b1;
                last_d        = PORT_LDR;
            end
        end
    end

    // Reset pretends the loader won last, so the LSU takes the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= PORT_LDR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - LSU/loader arbiter and sequencer for the byte-wide data RAM
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int W = 32,
    parameter int H = 8,
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lsu_req,
    input  logic         lsu_we,
    input  logic [W-1:0] lsu_addr,
    input  logic [W-1:0] lsu_wdat,
    input  logic [1:0]   lsu_size,
    input  logic         lsu_uns,
    output logic         lsu_gnt,
    output logic         lsu_rvalid,
    output logic [W-1:0] lsu_rdata,
    output logic         lsu_rerr,
    input  logic         ldr_req,
    input  logic         ldr_we,
    input  logic [W-1:0] ldr_addr,
    input  logic [W-1:0] ldr_wdat,
    input  logic [1:0]   ldr_size,
    input  logic         ldr_uns,
    output logic         ldr_gnt,
    output logic         ldr_rvalid,
    output logic [W-1:0] ldr_rdata,
    output logic         ldr_rerr,
    output logic         ram_we,
    output logic         ram_re,
    output logic [L-1:0] ram_type,
    output logic [W-1:0] ram_addr,
    output logic [W-1:0] ram_wdat,
    output logic         sign,
    input  logic [W-1:0] ram_rdat
);

    state_e       state_q, state_d;
    logic         port_q, port_d;
    logic         we_q, we_d;
    logic         uns_q, uns_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] wdat_q, wdat_d;
    logic [1:0]   size_q, size_d;
    logic         lsu_rvalid_q, lsu_rvalid_d;
    logic         ldr_rvalid_q, ldr_rvalid_d;
    logic         lsu_rerr_q, lsu_rerr_d;
    logic         ldr_rerr_q, ldr_rerr_d;
    logic [W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic [W-1:0] ldr_rdata_q, ldr_rdata_d;

    logic         arb_en;
    logic [1:0]   gnt;
    logic [1:0]   span;
    logic [L-1:0] type_dec;
    logic [H:0]   last_byte;
    logic         in_range;
    logic [W-1:0] resp_data;

    assign arb_en = rst_n && (state_q == IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({ldr_req, lsu_req}),
        .gnt   (gnt)
    );

    assign lsu_gnt = gnt[PORT_LSU];
    assign ldr_gnt = gnt[PORT_LDR];

    // Size decode: extra bytes past the start address, and the RAM one-hot
    always_comb begin
        span     = 2'd3;
        type_dec = RT_W;
        case (size_q)
            SZ_B:    begin span = 2'd0; type_dec = RT_B;  end
            SZ_H:    begin span = 2'd1; type_dec = RT_H;  end
            SZ_3B:   begin span = 2'd2; type_dec = RT_3B; end
            default: begin span = 2'd3; type_dec = RT_W;  end
        endcase
    end

    // Last touched byte must not carry out of the RAM window (no wrap-around)
    assign last_byte = {1'b0, addr_q[H-1:0]} + {{(H-1){1'b0}}, span};
    assign in_range  = (addr_q[W-1:H] == '0) && !last_byte[H];
    assign resp_data = (!we_q && in_range) ? ram_rdat : '0;

    // RAM drive is live only in ACCESS; strobes also die immediately on reset
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_type = '0;
        ram_addr = '0;
        ram_wdat = '0;
        sign     = 1'b0;
        if (state_q == ACCESS) begin
            ram_we   = we_q && in_range && rst_n;
            ram_re   = !we_q && in_range && rst_n;
            ram_type = type_dec;
            ram_addr = addr_q;
            ram_wdat = wdat_q;
            sign     = !we_q && !uns_q;
        end
    end

    // Next state: latch the granted command, then retire it into the owner's response regs
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        we_d         = we_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdat_d       = wdat_q;
        size_d       = size_q;
        lsu_rvalid_d = 1'b0;
        ldr_rvalid_d = 1'b0;
        lsu_rerr_d   = lsu_rerr_q;
        ldr_rerr_d   = ldr_rerr_q;
        lsu_rdata_d  = lsu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        if (state_q == IDLE) begin
            if (gnt[PORT_LDR]) begin
                state_d = ACCESS;
                port_d  = PORT_LDR;
                we_d    = ldr_we;
                uns_d   = ldr_uns;
                addr_d  = ldr_addr;
                wdat_d  = ldr_wdat;
                size_d  = ldr_size;
            end else if (gnt[PORT_LSU]) begin
                state_d = ACCESS;
                port_d  = PORT_LSU;
                we_d    = lsu_we;
                uns_d   = lsu_uns;
                addr_d  = lsu_addr;
                wdat_d  = lsu_wdat;
                size_d  = lsu_size;
            end
        end else begin
            state_d = IDLE;
            if (port_q == PORT_LSU) begin
                lsu_rvalid_d = 1'b1;
                lsu_rdata_d  = resp_data;
                lsu_rerr_d   = !in_range;
            end else begin
                ldr_rvalid_d = 1'b1;
                ldr_rdata_d  = resp_data;
                ldr_rerr_d   = !in_range;
            end
        end
    end

    // State, command and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            port_q       <= PORT_LSU;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdat_q       <= '0;
            size_q       <= SZ_B;
            lsu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            lsu_rerr_q   <= 1'b0;
            ldr_rerr_q   <= 1'b0;
            lsu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdat_q       <= wdat_d;
            size_q       <= size_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            ldr_rvalid_q <= ldr_rvalid_d;
            lsu_rerr_q   <= lsu_rerr_d;
            ldr_rerr_q   <= ldr_rerr_d;
            lsu_rdata_q  <= lsu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    assign lsu_rvalid = lsu_rvalid_q;
    assign ldr_rvalid = ldr_rvalid_q;
    assign lsu_rerr   = lsu_rerr_q;
    assign ldr_rerr   = ldr_rerr_q;
    assign lsu_rdata  = lsu_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;

endmodule
